// File: rtl/stage2_execute.sv
// ============================================================================
// Module   : stage2_execute
// Purpose  : Execute stage plus EX/MEM pipeline register. Selects forwarded
//            operands, runs the ALU, resolves branches/jumps, raises a
//            same-cycle redirect and kills the wrong-path instruction that
//            follows a redirect through a one-cycle squash FSM.
// Ports    : clk/rst_n           - clock, async active-low reset
//            stall/flush         - hold EX/MEM / load a bubble into EX/MEM
//            in_*                - operands, control, PC/immediate from ID/EX
//            fwd_a_sel/fwd_b_sel - 00 reg file, 01 wb_result, 10 o_alu_result
//            wb_result           - writeback-stage value for forwarding
//            o_alu_result..o_Result_Src - EX/MEM register outputs
//            o_pc_src/o_pc_target - redirect request and target
//            o_squash            - high while the squash FSM is in SQUASH
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage2_execute #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TGT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] in_A,
  input  logic [XLEN-1:0] in_B,
  input  logic [3:0]      in_control,
  input  logic [2:0]      in_funct3,
  input  logic            in_reg_write,
  input  logic            in_wed,
  input  logic            in_is_branch_instr,
  input  logic            in_is_jmp_instr,
  input  logic            in_is_jmpr_instr,
  input  logic            in_ALUSrc,
  input  logic [1:0]      in_Result_Src,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus_4,
  input  logic [XLEN-1:0] in_immediate,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_write_data,
  output logic [XLEN-1:0] o_pc_plus_4,
  output logic [4:0]      o_rd,
  output logic            o_reg_write,
  output logic            o_wed,
  output logic [1:0]      o_Result_Src,
  output logic            o_pc_src,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_squash
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SQUASH = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] alu_q, wdata_q, pc4_q, tgt_q;
  logic [4:0]      rd_q;
  logic            regw_q, wed_q;
  logic [1:0]      rsrc_q;

  logic [XLEN-1:0] fa, fb, src_b, alu_d, tgt_now;
  logic            cond, valid, take;

  // Operand forwarding; select 11 falls back to the register-file value.
  always_comb begin
    case (fwd_a_sel)
      2'b01:   fa = wb_result;
      2'b10:   fa = alu_q;
      default: fa = in_A;
    endcase
    case (fwd_b_sel)
      2'b01:   fb = wb_result;
      2'b10:   fb = alu_q;
      default: fb = in_B;
    endcase
  end

  assign src_b = in_ALUSrc ? in_immediate : fb;

  always_comb begin
    alu_d = '0;
    case (in_control)
      4'b0000: alu_d = fa + src_b;
      4'b0001: alu_d = fa - src_b;
      4'b0010: alu_d = fa & src_b;
      4'b0011: alu_d = fa | src_b;
      4'b0100: alu_d = fa ^ src_b;
      4'b0101: alu_d = fa << src_b[4:0];
      4'b0110: alu_d = fa >> src_b[4:0];
      4'b0111: alu_d = $signed(fa) >>> src_b[4:0];
      4'b1000: alu_d = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(src_b)};
      4'b1001: alu_d = {{(XLEN-1){1'b0}}, fa < src_b};
      4'b1010: alu_d = src_b;
      default: alu_d = '0;
    endcase
  end

  // Branch condition compares the forwarded operands, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (in_funct3)
      3'b000:  cond = (fa == fb);
      3'b001:  cond = (fa != fb);
      3'b100:  cond = ($signed(fa) <  $signed(fb));
      3'b101:  cond = ($signed(fa) >= $signed(fb));
      3'b110:  cond = (fa <  fb);
      3'b111:  cond = (fa >= fb);
      default: cond = 1'b0;
    endcase
  end

  // rst_n gates the redirect so it drops the instant reset is asserted.
  assign valid   = rst_n & (state_q != S_SQUASH) & ~stall;
  assign take    = valid & ((in_is_branch_instr & cond) | in_is_jmp_instr | in_is_jmpr_instr);
  assign tgt_now = in_is_jmpr_instr ? ((fa + in_immediate) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                    : (in_pc + in_immediate);

  assign o_pc_src    = take;
  assign o_pc_target = take ? tgt_now : tgt_q;
  assign o_squash    = (state_q == S_SQUASH);

  // Flush overrides stall for the FSM; a stalled FSM holds its state.
  always_comb begin
    state_d = state_q;
    if (flush || !stall) begin
      state_d = take ? S_SQUASH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= RESET_PC_TGT;
    end else begin
      state_q <= state_d;
      if (take) begin
        tgt_q <= tgt_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      wdata_q <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      regw_q  <= 1'b0;
      wed_q   <= 1'b0;
      rsrc_q  <= '0;
    end else if (flush || (!stall && state_q == S_SQUASH)) begin
      alu_q   <= '0;
      wdata_q <= '0;
      pc4_q   <= '0;
      rd_q    <= '0;
      regw_q  <= 1'b0;
      wed_q   <= 1'b0;
      rsrc_q  <= '0;
    end else if (!stall) begin
      alu_q   <= alu_d;
      wdata_q <= fb;
      pc4_q   <= in_pc_plus_4;
      rd_q    <= in_rd;
      regw_q  <= in_reg_write;
      wed_q   <= in_wed;
      rsrc_q  <= in_Result_Src;
    end
  end

  assign o_alu_result = alu_q;
  assign o_write_data = wdata_q;
  assign o_pc_plus_4  = pc4_q;
  assign o_rd         = rd_q;
  assign o_reg_write  = regw_q;
  assign o_wed        = wed_q;
  assign o_Result_Src = rsrc_q;

endmodule

`default_nettype wire

// File: tb/tb_stage2_execute.sv
// ============================================================================
// Module   : tb_stage2_execute
// Purpose  : Self-checking bench for stage2_execute. A behavioural model
//            tracks the expected EX/MEM contents, redirect and squash state;
//            a negedge process compares every output against it, and
//            directed steps pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage2_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] in_A, in_B, in_pc, in_pc_plus_4, in_immediate, wb_result;
  logic [3:0]  in_control;
  logic [2:0]  in_funct3;
  logic        in_reg_write, in_wed, in_is_branch_instr, in_is_jmp_instr;
  logic        in_is_jmpr_instr, in_ALUSrc;
  logic [1:0]  in_Result_Src, fwd_a_sel, fwd_b_sel;
  logic [4:0]  in_rd;
  logic [31:0] o_alu_result, o_write_data, o_pc_plus_4, o_pc_target;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_wed, o_pc_src, o_squash;
  logic [1:0]  o_Result_Src;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stage2_execute #(.XLEN(32), .RESET_PC_TGT(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_A(in_A), .in_B(in_B), .in_control(in_control), .in_funct3(in_funct3),
    .in_reg_write(in_reg_write), .in_wed(in_wed),
    .in_is_branch_instr(in_is_branch_instr), .in_is_jmp_instr(in_is_jmp_instr),
    .in_is_jmpr_instr(in_is_jmpr_instr), .in_ALUSrc(in_ALUSrc),
    .in_Result_Src(in_Result_Src), .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4),
    .in_immediate(in_immediate), .in_rd(in_rd),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_result(wb_result),
    .o_alu_result(o_alu_result), .o_write_data(o_write_data),
    .o_pc_plus_4(o_pc_plus_4), .o_rd(o_rd), .o_reg_write(o_reg_write),
    .o_wed(o_wed), .o_Result_Src(o_Result_Src), .o_pc_src(o_pc_src),
    .o_pc_target(o_pc_target), .o_squash(o_squash)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_alu, m_wd, m_pc4, m_tgt;
  logic [4:0]  m_rd;
  logic        m_rw, m_wed, m_sq;
  logic [1:0]  m_rs;

  function automatic logic [31:0] m_opnd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return wb_result;
    if (sel == 2'b10) return m_alu;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_take();
    logic [31:0] a, b;
    a = m_opnd(fwd_a_sel, in_A);
    b = m_opnd(fwd_b_sel, in_B);
    if (!rst_n || m_sq || stall) return 1'b0;
    return (in_is_branch_instr && m_cond(in_funct3, a, b)) || in_is_jmp_instr || in_is_jmpr_instr;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] a;
    a = m_opnd(fwd_a_sel, in_A);
    if (in_is_jmpr_instr) return ((a + in_immediate) / 2) * 2;
    return in_pc + in_immediate;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] a, b, sb;
    bit          tk;
    if (!rst_n) begin
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_tgt = 0; m_rd = 0;
      m_rw = 0; m_wed = 0; m_sq = 0; m_rs = 0;
    end else begin
      a  = m_opnd(fwd_a_sel, in_A);
      b  = m_opnd(fwd_b_sel, in_B);
      sb = in_ALUSrc ? in_immediate : b;
      tk = m_take();
      if (tk) m_tgt = m_target();
      if (flush || (!stall && m_sq)) begin
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rw = 0; m_wed = 0; m_rs = 0;
      end else if (!stall) begin
        m_alu = m_alu_fn(in_control, a, sb);
        m_wd  = b;
        m_pc4 = in_pc_plus_4;
        m_rd  = in_rd;
        m_rw  = in_reg_write;
        m_wed = in_wed;
        m_rs  = in_Result_Src;
      end
      if (flush || !stall) m_sq = tk;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("alu_result", o_alu_result, m_alu);
      chk("write_data", o_write_data, m_wd);
      chk("pc_plus_4",  o_pc_plus_4,  m_pc4);
      chk("rd",         32'(o_rd),    32'(m_rd));
      chk("reg_write",  32'(o_reg_write), 32'(m_rw));
      chk("wed",        32'(o_wed),   32'(m_wed));
      chk("result_src", 32'(o_Result_Src), 32'(m_rs));
      chk("squash",     32'(o_squash), 32'(m_sq));
      chk("pc_src",     32'(o_pc_src), 32'(m_take()));
      chk("pc_target",  o_pc_target,  m_take() ? m_target() : m_tgt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    in_A = 0; in_B = 0; in_control = 0; in_funct3 = 0;
    in_reg_write = 0; in_wed = 0; in_is_branch_instr = 0; in_is_jmp_instr = 0;
    in_is_jmpr_instr = 0; in_ALUSrc = 0; in_Result_Src = 0;
    in_pc = 0; in_pc_plus_4 = 0; in_immediate = 0; in_rd = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; wb_result = 0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    nop();
    repeat (2) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_alu",    o_alu_result, 32'h0);
    chk("rst_squash", 32'(o_squash), 32'h0);
    chk("rst_target", o_pc_target,  32'h0);

    // ALU
    in_A = 5; in_B = 3; in_control = 4'd1; in_reg_write = 1; in_rd = 3; in_Result_Src = 2'b01;
    cyc();
    chk("sub", o_alu_result, 32'h2);
    chk("sub_rd", 32'(o_rd), 32'd3);
    in_A = 32'h8000_0000; in_immediate = 4; in_ALUSrc = 1; in_control = 4'd7;
    cyc();
    chk("sra", o_alu_result, 32'hF800_0000);
    in_A = 32'hFFFF_FFFF; in_B = 1; in_ALUSrc = 0; in_control = 4'd8;
    cyc();
    chk("slt", o_alu_result, 32'h1);
    in_control = 4'd9;
    cyc();
    chk("sltu", o_alu_result, 32'h0);

    // Forwarding
    in_A = 3; in_B = 4; in_control = 4'd0;
    cyc();
    in_A = 32'h100; in_B = 1; fwd_a_sel = 2'b10;
    cyc();
    chk("fwd_a_alu", o_alu_result, 32'h8);
    fwd_a_sel = 2'b00; in_A = 0; fwd_b_sel = 2'b01; wb_result = 9; in_wed = 1; in_B = 55;
    cyc();
    chk("fwd_b_wb", o_write_data, 32'h9);
    chk("fwd_b_wed", 32'(o_wed), 32'h1);

    // BEQ taken, then the next instruction is squashed
    nop();
    in_A = 4; in_B = 4; in_is_branch_instr = 1; in_pc = 32'h100; in_immediate = 32'h20; in_control = 4'd1;
    #1;
    chk("beq_src", 32'(o_pc_src), 32'h1);
    chk("beq_tgt", o_pc_target, 32'h120);
    cyc();
    nop();
    in_reg_write = 1; in_rd = 7; in_A = 1; in_B = 2;
    #1;
    chk("beq_squash", 32'(o_squash), 32'h1);
    chk("beq_nosrc",  32'(o_pc_src), 32'h0);
    cyc();
    chk("bubble_rw",  32'(o_reg_write), 32'h0);
    chk("bubble_rd",  32'(o_rd), 32'h0);
    chk("squash_end", 32'(o_squash), 32'h0);
    chk("tgt_hold",   o_pc_target, 32'h120);

    // JALR
    nop();
    in_is_jmpr_instr = 1; in_A = 32'h1003; in_immediate = 4; in_pc = 32'h200;
    in_pc_plus_4 = 32'h204; in_reg_write = 1; in_rd = 1; in_Result_Src = 2'b10;
    #1;
    chk("jalr_src", 32'(o_pc_src), 32'h1);
    chk("jalr_tgt", o_pc_target, 32'h1006);
    cyc();
    chk("jalr_link", o_pc_plus_4, 32'h204);
    nop();
    cyc();
    chk("jalr_bubble_pc4", o_pc_plus_4, 32'h0);

    // Stall during a taken branch, then stall during SQUASH
    in_is_branch_instr = 1; in_funct3 = 3'd1; in_A = 1; in_B = 2;
    in_pc = 32'h300; in_immediate = 32'h40; stall = 1;
    #1;
    chk("stall_nosrc", 32'(o_pc_src), 32'h0);
    cyc();
    chk("stall_hold", o_alu_result, 32'h0);
    chk("stall_nosq", 32'(o_squash), 32'h0);
    stall = 0;
    #1;
    chk("unstall_src", 32'(o_pc_src), 32'h1);
    chk("unstall_tgt", o_pc_target, 32'h340);
    cyc();
    chk("once_nosrc", 32'(o_pc_src), 32'h0);
    chk("once_squash", 32'(o_squash), 32'h1);
    nop();
    stall = 1;
    cyc();
    chk("sq_stall1", 32'(o_squash), 32'h1);
    cyc();
    chk("sq_stall2", 32'(o_squash), 32'h1);
    stall = 0;
    cyc();
    chk("sq_release", 32'(o_squash), 32'h0);

    // Simultaneous take and flush
    in_is_jmp_instr = 1; in_pc = 32'h400; in_immediate = 8; in_reg_write = 1; in_rd = 5; flush = 1;
    #1;
    chk("flush_src", 32'(o_pc_src), 32'h1);
    chk("flush_tgt", o_pc_target, 32'h408);
    cyc();
    chk("flush_rw", 32'(o_reg_write), 32'h0);
    chk("flush_sq", 32'(o_squash), 32'h1);
    flush = 0;
    nop();
    cyc();

    // Sweep of every ALU code, then every branch condition
    for (int i = 0; i < 16; i++) begin
      in_control = 4'(i); in_A = 32'h9ABC_DEF0; in_B = 32'h0000_0024;
      in_reg_write = 1; in_rd = 5'(i);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      nop();
      in_is_branch_instr = 1; in_funct3 = 3'(i); in_A = 32'hFFFF_FFFD; in_B = 5;
      in_pc = 32'h600 + 32'(i * 16); in_immediate = 32'h10;
      cyc();
      nop();
      cyc();
    end

    // Asynchronous reset mid-squash and mid-stall
    in_is_jmp_instr = 1; in_pc = 32'h500; in_immediate = 32'h10; in_reg_write = 1;
    in_rd = 9; in_A = 5; in_B = 3;
    cyc();
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    chk("arst_alu",    o_alu_result, 32'h0);
    chk("arst_rd",     32'(o_rd), 32'h0);
    chk("arst_rw",     32'(o_reg_write), 32'h0);
    chk("arst_pc4",    o_pc_plus_4, 32'h0);
    chk("arst_squash", 32'(o_squash), 32'h0);
    chk("arst_tgt",    o_pc_target, 32'h0);
    chk("arst_src",    32'(o_pc_src), 32'h0);
    stall = 0;
    #1;
    chk("arst_src_jmp", 32'(o_pc_src), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage2_execute.md
Name: stage2_execute

Overview:
- Execute stage and EX/MEM pipeline register. Sits directly downstream of the ID/EX register.
- Consumes that register's operands, control and PC/immediate fields; performs operand forwarding, ALU operation, branch/jump resolution and redirect generation.
- Registers the memory-stage bundle.
- Contains a one-cycle squash FSM so a wrong-path instruction already in ID/EX is killed after a redirect.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_TGT, 32'h0, value of o_pc_target after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold EX/MEM register; suppress redirect.
- flush  in  1  load a bubble into EX/MEM on the next edge.
- in_A, in_B  in  XLEN  register-file operands from ID/EX.
- in_control  in  4  ALU op.
- in_funct3  in  3  branch condition.
- in_reg_write, in_wed, in_is_branch_instr, in_is_jmp_instr, in_is_jmpr_instr, in_ALUSrc  in  1 each  control from ID/EX.
- in_Result_Src  in  2  writeback select, passed through.
- in_pc, in_pc_plus_4, in_immediate  in  XLEN  from ID/EX.
- in_rd  in  5  destination register.
- fwd_a_sel, fwd_b_sel  in  2  forwarding select: 00 = in_A/in_B, 01 = wb_result, 10 = o_alu_result.
- wb_result  in  XLEN  writeback-stage value.
- o_alu_result, o_write_data, o_pc_plus_4  out  XLEN  EX/MEM register.
- o_rd  out  5  EX/MEM register.
- o_reg_write, o_wed  out  1  EX/MEM register.
- o_Result_Src  out  2  EX/MEM register.
- o_pc_src  out  1  combinational redirect request.
- o_pc_target  out  XLEN  combinational redirect target; holds the last target when idle.
- o_squash  out  1  registered; high while the FSM is in SQUASH.

Behaviour:
- Operands:
  - fa = mux(fwd_a_sel), fb = mux(fwd_b_sel); select 11 behaves as 00.
  - srcB = in_ALUSrc ? in_immediate : fb.
  - o_write_data captures fb, not srcB.
- ALU (in_control) on fa, srcB:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is srcB[4:0].
  - 1000 SLT (signed), 1001 SLTU, 1010 pass srcB (LUI).
  - All other codes give 0. Arithmetic wraps mod 2^XLEN.
- Branch compare on fa, fb by in_funct3:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 give not-taken.
- Redirect:
  - take = valid & ((in_is_branch_instr & cond) | in_is_jmp_instr | in_is_jmpr_instr).
  - valid = !squash_state & !stall.
  - o_pc_src = take.
  - Target: jmpr gives (fa + in_immediate) & ~1; otherwise in_pc + in_immediate. Jmpr has priority if several flags are set.
  - o_pc_target is registered-hold: it updates whenever take is high, otherwise it keeps its previous value. Reset value is RESET_PC_TGT.
- Squash FSM (IDLE, SQUASH):
  - IDLE -> SQUASH on an edge with take = 1.
  - SQUASH -> IDLE on the next edge that is not stalled. While stalled, the FSM stays in SQUASH.
  - In SQUASH, the current EX instruction is killed: no redirect, and a bubble is loaded into EX/MEM.
  - o_squash = (state == SQUASH).
- EX/MEM register, priority order:
  1. rst_n low: all outputs 0, FSM to IDLE, o_pc_target = RESET_PC_TGT. Asynchronous, including mid-stall or mid-squash.
  2. flush: bubble (reg_write = 0, wed = 0, rd = 0, data 0). FSM goes to IDLE unless take.
  3. stall: hold all register outputs and the FSM.
  4. squash_state: bubble.
  5. Otherwise capture the ALU result and pass the remaining fields through.
- Latency:
  - ALU result is visible on o_alu_result one edge after inputs are presented.
  - o_pc_src is visible in the same cycle.
- Simultaneous take and flush: the redirect still fires and the FSM enters SQUASH. The flush only bubbles EX/MEM.
- A taken branch does not itself bubble its own EX/MEM slot (jumps need the link value). The branch writes reg_write as provided by in_reg_write.

Test Plan:
- Reset: drive rst_n low mid-operation with non-zero state -> all EX/MEM outputs 0, o_pc_src 0, o_pc_target 0, o_squash 0 immediately, without waiting for a clock edge.
- ALU: in_A = 5, in_B = 3, SUB -> o_alu_result = 2 after 1 edge. in_A = 32'h80000000, SRA, imm = 4 with ALUSrc -> 32'hF8000000. SLT with -1 vs 1 -> 1. SLTU with the same operands -> 0.
- Forwarding: fwd_a_sel = 10, previous o_alu_result = 7, in_control ADD, in_B = 1 -> 8. fwd_b_sel = 01, wb_result = 9, wed = 1 -> o_write_data = 9.
- Branch: BEQ with fa = fb = 4, in_pc = 32'h100, imm = 32'h20 -> o_pc_src = 1, o_pc_target = 32'h120. Next cycle: o_squash = 1, and a reg_write = 1 instruction produces a bubble.
- JALR: fa = 32'h1003, imm = 4 -> target 32'h1006, o_pc_plus_4 passed through.
- Stall: assert stall during a taken branch -> o_pc_src = 0 and outputs held. Release stall -> redirect fires exactly once. Stall during SQUASH -> o_squash stays 1 until the first unstalled edge.
